i2s_sample_scheduler: RTL and testbench

Stereo sample scheduler between the USB audio stream receiver and `i2s_master`. Buffers incoming left/right sample pairs in a small ring FIFO. Holds playback muted until a start level is reached. Stages the next pair on the master's `left_channel`/`right_channel` inputs and advances on each one-cycle `en` frame request. Reports FIFO level for USB rate feedback and flags underrun/overflow.

---
 rtl/i2s_sample_scheduler_pkg.sv | 14 +
 rtl/i2s_sample_scheduler_if.sv | 13 +
 rtl/i2s_sample_scheduler_stereo_fifo.sv | 42 ++++
 rtl/i2s_sample_scheduler.sv | 131 +++++++++++++
 tb/tb_i2s_sample_scheduler.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/i2s_sample_scheduler_pkg.sv
// Shared types and constants for the I2S sample scheduler.
package i2s_sched_pkg;

   localparam int unsigned SAMPLE_W = 32;
   localparam int unsigned PAIR_W   = 2 * SAMPLE_W;
   localparam int unsigned CNT_W    = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      S_MUTE = 2'b01,
      S_PLAY = 2'b10
   } state_e;

endpackage

// File: rtl/i2s_sample_scheduler_if.sv
// Sample-pair stream from the USB receiver into the scheduler.
interface i2s_sched_if;
   import i2s_sched_pkg::*;

   logic                in_valid;
   logic [SAMPLE_W-1:0] in_left;
   logic [SAMPLE_W-1:0] in_right;
   logic                in_ready;

   modport master (output in_valid, output in_left, output in_right, input in_ready);
   modport slave  (input in_valid, input in_left, input in_right, output in_ready);

endinterface

// File: rtl/i2s_sample_scheduler_stereo_fifo.sv
// Ring FIFO of stereo pairs; pointers carry a wrap bit so full/empty need no extra flag.
module stereo_fifo
   import i2s_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [PAIR_W-1:0] wdata,
   output logic [PAIR_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       level
);

   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [PAIR_W-1:0] mem_q [DEPTH];

   assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
   assign empty = wr_ptr_q == rd_ptr_q;
   assign level = wr_ptr_q - rd_ptr_q;
   assign rdata = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/i2s_sample_scheduler.sv
// Buffers stereo pairs and stages one per i2s_master frame request.
// Define I2S_SCHED_STATS_EN to build the saturating underrun/overflow counters.
module i2s_sample_scheduler
   import i2s_sched_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned START_LEVEL = DEPTH / 2,
   localparam int unsigned AW         = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                play_en,
   i2s_sched_if.slave          src,
   input  logic                en,
   output logic [SAMPLE_W-1:0] left_channel,
   output logic [SAMPLE_W-1:0] right_channel,
   output logic [AW:0]         level,
   output logic                playing,
   output logic                underrun,
   output logic                overflow,
   input  logic                stats_clr,
   output logic [CNT_W-1:0]    underrun_cnt,
   output logic [CNT_W-1:0]    overflow_cnt
);

   state_e              state_q;
   logic                play_en_q;
   logic                stage_vld_q;
   logic [SAMPLE_W-1:0] stage_l_q, stage_r_q;
   logic                underrun_q, overflow_q;

   logic              full, empty, push, drop, pop, ur_evt;
   logic [PAIR_W-1:0] rdata;

   // Ready is decoded from flops only so reset holds it low.
   assign src.in_ready = play_en_q && !full;
   assign push   = play_en && src.in_valid && src.in_ready;
   assign drop   = play_en && src.in_valid && !src.in_ready;
   assign pop    = (state_q == S_PLAY) && play_en && !en && !stage_vld_q && !empty;
   assign ur_evt = (state_q == S_PLAY) && play_en && en && !stage_vld_q;

   stereo_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (!play_en),
      .push  (push),
      .pop   (pop),
      .wdata ({src.in_left, src.in_right}),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_MUTE;
         play_en_q   <= 1'b0;
         stage_vld_q <= 1'b0;
         stage_l_q   <= '0;
         stage_r_q   <= '0;
         underrun_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         play_en_q  <= play_en;
         underrun_q <= ur_evt;
         overflow_q <= drop;
         if (!play_en) begin
            state_q     <= S_MUTE;
            stage_vld_q <= 1'b0;
            stage_l_q   <= '0;
            stage_r_q   <= '0;
         end else begin
            unique case (state_q)
               S_MUTE: begin
                  stage_vld_q <= 1'b0;
                  stage_l_q   <= '0;
                  stage_r_q   <= '0;
                  if (level >= (AW+1)'(START_LEVEL)) state_q <= S_PLAY;
               end
               S_PLAY: begin
                  // A consume in the same cycle defers any load by one cycle.
                  if (en && stage_vld_q) begin
                     stage_vld_q <= 1'b0;
                  end else if (ur_evt) begin
                     stage_l_q <= '0;
                     stage_r_q <= '0;
                     state_q   <= S_MUTE;
                  end else if (pop) begin
                     stage_l_q   <= rdata[PAIR_W-1:SAMPLE_W];
                     stage_r_q   <= rdata[SAMPLE_W-1:0];
                     stage_vld_q <= 1'b1;
                  end
               end
               default: state_q <= S_MUTE;
            endcase
         end
      end
   end

   assign left_channel  = stage_l_q;
   assign right_channel = stage_r_q;
   assign playing       = state_q == S_PLAY;
   assign underrun      = underrun_q;
   assign overflow      = overflow_q;

`ifdef I2S_SCHED_STATS_EN
   logic [CNT_W-1:0] underrun_cnt_q, overflow_cnt_q;

   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         underrun_cnt_q <= '0;
         overflow_cnt_q <= '0;
      end else begin
         if (ur_evt && underrun_cnt_q != CNT_MAX) underrun_cnt_q <= underrun_cnt_q + 1'b1;
         if (drop && overflow_cnt_q != CNT_MAX)   overflow_cnt_q <= overflow_cnt_q + 1'b1;
      end
   end

   assign underrun_cnt = underrun_cnt_q;
   assign overflow_cnt = overflow_cnt_q;
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;
   assign underrun_cnt     = '0;
   assign overflow_cnt     = '0;
`endif

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Scoreboard bench: pushed pairs are queued and checked as each frame request consumes them.
module tb_i2s_sample_scheduler;
   import i2s_sched_pkg::*;

`ifdef I2S_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst, play_en, en, stats_clr;
   logic [SAMPLE_W-1:0] left_channel, right_channel;
   logic [4:0]          level;
   logic                playing, underrun, overflow;
   logic [CNT_W-1:0]    underrun_cnt, overflow_cnt;

   i2s_sched_if src_if ();

   i2s_sample_scheduler #(
      .DEPTH       (16),
      .START_LEVEL (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .play_en       (play_en),
      .src           (src_if),
      .en            (en),
      .left_channel  (left_channel),
      .right_channel (right_channel),
      .level         (level),
      .playing       (playing),
      .underrun      (underrun),
      .overflow      (overflow),
      .stats_clr     (stats_clr),
      .underrun_cnt  (underrun_cnt),
      .overflow_cnt  (overflow_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned ur_seen  = 0;
   int unsigned ov_seen  = 0;
   logic [63:0] sb_q [$];

   always @(negedge clk) begin
      if (!rst && underrun) ur_seen++;
      if (!rst && overflow) ov_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare the staged pair with the scoreboard head, then consume it.
   task automatic frame(input string tag);
      logic [63:0] exp;
      exp = sb_q.pop_front();
      check({tag, "_l"}, left_channel, exp[63:32]);
      check({tag, "_r"}, right_channel, exp[31:0]);
      en = 1'b1;
      tick();
      en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int unsigned acc, drops;
      rst = 1'b1; play_en = 1'b1; en = 1'b0; stats_clr = 1'b0;
      src_if.in_valid = 1'b0; src_if.in_left = '0; src_if.in_right = '0;
      repeat (3) tick();
      check("rst_ready", src_if.in_ready, 0);
      check("rst_level", level, 0);
      check("rst_playing", playing, 0);
      check("rst_left", left_channel, 0);
      rst = 1'b0;
      tick();
      check("ready_after_rst", src_if.in_ready, 1);

      // Below start level: stay muted.
      for (int i = 0; i < 7; i++) begin
         src_if.in_valid = 1'b1;
         src_if.in_left  = 32'hA000_0000 + i;
         src_if.in_right = 32'hB000_0000 + i;
         sb_q.push_back({src_if.in_left, src_if.in_right});
         tick();
      end
      src_if.in_valid = 1'b0;
      repeat (2) tick();
      check("mute_playing", playing, 0);
      check("mute_left", left_channel, 0);
      check("mute_level", level, 7);

      src_if.in_valid = 1'b1;
      src_if.in_left  = 32'hA000_0007;
      src_if.in_right = 32'hB000_0007;
      sb_q.push_back({src_if.in_left, src_if.in_right});
      tick();
      src_if.in_valid = 1'b0;
      check("level8_playing", playing, 0);
      tick();
      check("play_entered", playing, 1);
      check("play_not_staged", left_channel, 0);
      tick();
      check("first_load_level", level, 7);

      // Drain at one request per 128-clock frame, then underrun.
      for (int n = 0; n < 9; n++) begin
         repeat (126) tick();
         if (sb_q.size() > 0) begin
            frame("drain");
            check("drain_no_underrun", underrun, 0);
            tick();
            check("drain_level", level, sb_q.size() > 0 ? sb_q.size() - 1 : 0);
         end else begin
            check("hold_last_l", left_channel, 32'hA000_0007);
            en = 1'b1;
            tick();
            en = 1'b0;
            check("underrun_pulse", underrun, 1);
            check("underrun_playing", playing, 0);
            check("underrun_left", left_channel, 0);
            check("underrun_right", right_channel, 0);
            check("underrun_cnt", underrun_cnt, STATS ? 1 : 0);
            tick();
            check("underrun_one_cycle", underrun, 0);
         end
      end

      // Overfill: 17 accepted (16 in FIFO plus the staged pair), then 3 drops.
      acc = 0; drops = 0;
      for (int i = 0; i < 20; i++) begin
         src_if.in_valid = 1'b1;
         src_if.in_left  = 32'hC000_0000 + i;
         src_if.in_right = 32'hE000_0000 + i;
         if (src_if.in_ready) begin
            sb_q.push_back({src_if.in_left, src_if.in_right});
            acc++;
         end else begin
            drops++;
         end
         tick();
      end
      src_if.in_valid = 1'b0;
      tick();
      check("ovf_accepted", acc, 17);
      check("ovf_drops", drops, 3);
      check("ovf_pulses", ov_seen, 3);
      check("ovf_level", level, 16);
      check("ovf_ready", src_if.in_ready, 0);
      check("ovf_cnt", overflow_cnt, STATS ? 3 : 0);

      // Consume six pairs to reach level 10, then drop play_en.
      for (int k = 0; k < 6; k++) begin
         frame("mid");
         repeat (3) tick();
      end
      check("mid_level", level, 10);
      play_en = 1'b0;
      src_if.in_valid = 1'b1;
      tick();
      src_if.in_valid = 1'b0;
      check("flush_level", level, 0);
      check("flush_left", left_channel, 0);
      check("flush_right", right_channel, 0);
      check("flush_playing", playing, 0);
      check("flush_no_overflow", overflow, 0);
      check("flush_no_underrun", underrun, 0);
      sb_q.delete();
      play_en = 1'b1;
      tick();

      // Back-to-back requests force an underrun coinciding with a stats clear.
      for (int i = 0; i < 8; i++) begin
         src_if.in_valid = 1'b1;
         src_if.in_left  = 32'hD000_0000 + i;
         src_if.in_right = 32'h9000_0000 + i;
         sb_q.push_back({src_if.in_left, src_if.in_right});
         tick();
      end
      src_if.in_valid = 1'b0;
      repeat (2) tick();
      frame("restart");
      en = 1'b1;
      stats_clr = 1'b1;
      tick();
      en = 1'b0;
      stats_clr = 1'b0;
      check("clr_underrun_pulse", underrun, 1);
      check("clr_underrun_cnt", underrun_cnt, 0);
      check("clr_overflow_cnt", overflow_cnt, 0);
      tick();
      check("clr_cnt_stays", underrun_cnt, 0);
      check("total_underruns", ur_seen, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
